// File: rtl/mag_share_arb.sv
// mag_share_arb: shares one fixed-latency magnitude unit between two requester
// streams. Each stream is buffered in a small FIFO. A round-robin arbiter issues
// one sample per cycle to the unit. A {valid,id} tag pipe tracks every issued
// sample, so each result is routed back to the requester that issued it.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   reqN_ena/real/imag, reqN_rdy   requester N sample in, buffer-not-full
//   mag_ena/real/imag              registered issue to the magnitude unit
//   mag_in, mag_val                magnitude unit result
//   outN_val, outN_mag             registered result pulse for requester N
//   err                            sticky tag/result misalignment flag

// Per-requester FIFO. Pointers wrap at DEPTH, so DEPTH need not be a power of 2.
module mag_share_fifo #(
    parameter int W     = 44,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         nempty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage carries no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= inc(wptr);
            if (pop)  rptr <= inc(rptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout   = mem[rptr];
    assign nempty = (count != '0);
    assign full   = (count == CW'(DEPTH));
endmodule

module mag_share_arb #(
    parameter int DW    = 22,
    parameter int LAT   = 3,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_ena,
    input  logic [DW-1:0] req0_real,
    input  logic [DW-1:0] req0_imag,
    output logic          req0_rdy,
    input  logic          req1_ena,
    input  logic [DW-1:0] req1_real,
    input  logic [DW-1:0] req1_imag,
    output logic          req1_rdy,
    output logic          mag_ena,
    output logic [DW-1:0] mag_real,
    output logic [DW-1:0] mag_imag,
    input  logic [DW:0]   mag_in,
    input  logic          mag_val,
    output logic          out0_val,
    output logic [DW:0]   out0_mag,
    output logic          out1_val,
    output logic [DW:0]   out1_mag,
    output logic          err
);
    localparam int NREQ = 2;

    logic [NREQ-1:0]           ena, rdy, full, push, pop, nempty;
    logic [NREQ-1:0][2*DW-1:0] din, dout;
    logic                      gnt, gnt_id, prio;
    logic [LAT:0]              vld_pipe, id_pipe;
    logic                      ret;

    assign ena      = {req1_ena, req0_ena};
    assign din[0]   = {req0_real, req0_imag};
    assign din[1]   = {req1_real, req1_imag};
    // rdy comes from the registered count only, forced low while in reset.
    assign rdy      = ~full & {NREQ{~rst}};
    assign push     = ena & rdy;
    assign req0_rdy = rdy[0];
    assign req1_rdy = rdy[1];

    for (genvar i = 0; i < NREQ; i++) begin : g_req
        mag_share_fifo #(.W(2 * DW), .DEPTH(DEPTH)) u_fifo (
            .clk    (clk),
            .rst    (rst),
            .push   (push[i]),
            .din    (din[i]),
            .pop    (pop[i]),
            .dout   (dout[i]),
            .nempty (nempty[i]),
            .full   (full[i])
        );
    end

    // prio names the requester that wins a tie; it flips to the other side
    // after every grant, so two busy streams alternate slots.
    always_comb begin
        gnt    = 1'b0;
        gnt_id = 1'b0;
        if (&nempty) begin
            gnt    = 1'b1;
            gnt_id = prio;
        end else if (nempty[0]) begin
            gnt    = 1'b1;
            gnt_id = 1'b0;
        end else if (nempty[1]) begin
            gnt    = 1'b1;
            gnt_id = 1'b1;
        end
    end

    assign pop = gnt ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
    // Stage LAT lines up with mag_val because stage 0 loads on the same edge as mag_ena.
    assign ret = mag_val & vld_pipe[LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            mag_ena  <= 1'b0;
            mag_real <= '0;
            mag_imag <= '0;
            prio     <= 1'b0;
            vld_pipe <= '0;
            id_pipe  <= '0;
            out0_val <= 1'b0;
            out0_mag <= '0;
            out1_val <= 1'b0;
            out1_mag <= '0;
            err      <= 1'b0;
        end else begin
            mag_ena <= gnt;
            if (gnt) begin
                {mag_real, mag_imag} <= dout[gnt_id];
                prio                 <= ~gnt_id;
            end
            vld_pipe <= {vld_pipe[LAT-1:0], gnt};
            id_pipe  <= {id_pipe[LAT-1:0], gnt_id};
            out0_val <= ret & ~id_pipe[LAT];
            out1_val <= ret & id_pipe[LAT];
            if (ret & ~id_pipe[LAT]) out0_mag <= mag_in;
            if (ret & id_pipe[LAT])  out1_mag <= mag_in;
            // A result without a tag, or a tag without a result, means the
            // unit and the tag pipe have lost alignment; untagged results are dropped.
            err <= err | (mag_val ^ vld_pipe[LAT]);
        end
    end
endmodule

// File: tb/tb_mag_share_arb.sv
module tb_mag_share_arb;
    localparam int DW = 22, LAT = 3, DEPTH = 2;

    logic clk = 1'b0, rst = 1'b1;
    logic req0_ena = 0, req1_ena = 0, inject = 0;
    logic [DW-1:0] req0_real = '0, req0_imag = '0, req1_real = '0, req1_imag = '0;
    logic req0_rdy, req1_rdy, mag_ena, mag_val, out0_val, out1_val, err;
    logic [DW-1:0] mag_real, mag_imag;
    logic [DW:0] mag_in, out0_mag, out1_mag;

    always #5 clk = ~clk;

    mag_share_arb #(.DW(DW), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req0_ena(req0_ena), .req0_real(req0_real), .req0_imag(req0_imag), .req0_rdy(req0_rdy),
        .req1_ena(req1_ena), .req1_real(req1_real), .req1_imag(req1_imag), .req1_rdy(req1_rdy),
        .mag_ena(mag_ena), .mag_real(mag_real), .mag_imag(mag_imag),
        .mag_in(mag_in), .mag_val(mag_val),
        .out0_val(out0_val), .out0_mag(out0_mag), .out1_val(out1_val), .out1_mag(out1_mag),
        .err(err)
    );

    // mag = max(|re|,|im|) + min(|re|,|im|)/2
    function automatic logic [DW:0] fmag(input logic [DW-1:0] re, input logic [DW-1:0] im);
        int a, b, mx, mn;
        a = int'($signed(re));
        b = int'($signed(im));
        if (a < 0) a = -a;
        if (b < 0) b = -b;
        mx = (a > b) ? a : b;
        mn = (a > b) ? b : a;
        return (DW + 1)'(mx + (mn >> 1));
    endfunction

    // Behavioural magnitude unit: LAT cycles, no stall, shares rst.
    logic [LAT-1:0] u_v;
    logic [DW:0]    u_m [LAT];
    always @(posedge clk) begin
        if (rst) u_v <= '0;
        else begin
            u_v    <= {u_v[LAT-2:0], mag_ena};
            u_m[0] <= fmag(mag_real, mag_imag);
            for (int i = 1; i < LAT; i++) u_m[i] <= u_m[i-1];
        end
    end
    assign mag_val = u_v[LAT-1] | inject;
    assign mag_in  = u_m[LAT-1];

    // Reference model: buffer contents, tie-break owner and scheduled results.
    typedef struct { int due; bit id; logic [DW:0] mag; } fl_t;
    logic [2*DW-1:0] q0[$], q1[$];
    fl_t fl[$];
    bit prio = 0, exp_ena = 0, exp_err = 0;
    logic [DW-1:0] exp_re = '0, exp_im = '0;
    logic [DW:0] last0 = '0, last1 = '0;
    int cyc = 0, checks = 0, failures = 0;
    bit ob_ena, ob_v0, ob_v1, ob_err, ob_r0, ob_r1;
    logic [DW:0] ob_m0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input bit r, input bit e0, input logic [DW-1:0] re0, input logic [DW-1:0] im0,
                        input bit e1, input logic [DW-1:0] re1, input logic [DW-1:0] im1, input bit inj);
        bit er0, er1, ev0, ev1, n0, n1, g, gid;
        logic [2*DW-1:0] s;
        fl_t f;
        @(negedge clk);
        cyc++;
        rst = r;
        inject = inj;
        #1;
        er0 = !r && q0.size() != DEPTH;
        er1 = !r && q1.size() != DEPTH;
        ev0 = 0; ev1 = 0;
        if (fl.size() > 0 && fl[0].due == cyc) begin
            f = fl.pop_front();
            if (f.id) begin ev1 = 1; last1 = f.mag; end
            else begin ev0 = 1; last0 = f.mag; end
        end
        check("rdy0", req0_rdy, er0);
        check("rdy1", req1_rdy, er1);
        check("mag_ena", mag_ena, exp_ena);
        if (exp_ena) begin
            check("mag_real", mag_real, exp_re);
            check("mag_imag", mag_imag, exp_im);
        end
        check("out0_val", out0_val, ev0);
        check("out0_mag", out0_mag, last0);
        check("out1_val", out1_val, ev1);
        check("out1_mag", out1_mag, last1);
        check("err", err, exp_err);
        ob_ena = mag_ena; ob_v0 = out0_val; ob_v1 = out1_val; ob_m0 = out0_mag;
        ob_err = err; ob_r0 = req0_rdy; ob_r1 = req1_rdy;
        req0_ena = e0; req0_real = re0; req0_imag = im0;
        req1_ena = e1; req1_real = re1; req1_imag = im1;
        // Advance the model across the coming clock edge.
        if (r) begin
            q0.delete(); q1.delete(); fl.delete();
            prio = 0; exp_ena = 0; exp_err = 0; last0 = '0; last1 = '0;
        end else begin
            if (inj) exp_err = 1;  // only injected while nothing is in flight
            n0 = q0.size() > 0;
            n1 = q1.size() > 0;
            g = n0 || n1;
            gid = (n0 && n1) ? prio : !n0;
            if (g) begin
                s = gid ? q1.pop_front() : q0.pop_front();
                {exp_re, exp_im} = s;
                fl.push_back('{cyc + LAT + 2, gid, fmag(s[2*DW-1:DW], s[DW-1:0])});
                prio = !gid;
            end
            exp_ena = g;
            if (e0 && er0) q0.push_back({re0, im0});
            if (e1 && er1) q1.push_back({re1, im1});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick(0, 0, '0, '0, 0, '0, '0, 0);
    endtask

    task automatic rnd(input int n, input bit p0, input bit p1, input bit r);
        repeat (n) tick(r, p0, DW'($urandom), DW'($urandom), p1, DW'($urandom), DW'($urandom), 0);
    endtask

    int n_ena, n_out1;
    logic [DW-1:0] m3;

    initial begin
        repeat (2) @(posedge clk);
        tick(1, 0, '0, '0, 0, '0, '0, 0);
        tick(1, 0, '0, '0, 0, '0, '0, 0);
        while (cyc < 9) idle(1);

        // 1: single req0 sample, accepted in cycle 10
        m3 = DW'(-3);
        tick(0, 1, m3, DW'(4), 0, '0, '0, 0);
        idle(2);
        check("t1_ena_c12", ob_ena, 1'b1);
        idle(4);
        check("t1_out0_c16", ob_v0, 1'b1);
        check("t1_mag5", ob_m0, (DW + 1)'(5));
        check("t1_no_out1", ob_v1, 1'b0);
        idle(4);

        // 2: both saturating for 20 cycles
        rnd(20, 1, 1, 0);
        idle(10);

        // 3: req1 alone, 16 back-to-back samples
        n_ena = 0; n_out1 = 0;
        repeat (16) begin
            tick(0, 0, '0, '0, 1, DW'($urandom), DW'($urandom), 0);
            n_ena += int'(ob_ena); n_out1 += int'(ob_v1);
            check("t3_rdy1", ob_r1, 1'b1);
        end
        repeat (10) begin
            idle(1);
            n_ena += int'(ob_ena); n_out1 += int'(ob_v1);
        end
        check("t3_ena_count", n_ena, 16);
        check("t3_out1_count", n_out1, 16);

        // 4: both buffers held full while pushing/popping
        rnd(12, 1, 1, 0);

        // 5: reset with both buffers full and samples in flight
        rnd(1, 1, 1, 1);
        idle(1);
        check("t5_rdy0_after", ob_r0, 1'b1);
        check("t5_rdy1_after", ob_r1, 1'b1);
        idle(10);

        // 6: spurious mag_val with an empty tag pipe
        tick(0, 0, '0, '0, 0, '0, '0, 1);
        idle(1);
        check("t6_err_set", ob_err, 1'b1);
        idle(5);
        check("t6_err_sticky", ob_err, 1'b1);
        tick(1, 0, '0, '0, 0, '0, '0, 0);
        idle(1);
        check("t6_err_clr", ob_err, 1'b0);

        // Random traffic
        repeat (150) rnd(1, 1'($urandom), 1'($urandom), 0);
        idle(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
